// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Sends one frame per accepted start: a low start bit, NB_DATA data bits LSB-first,
// then a high stop period. Bit timing counts i_tick pulses from the baud-rate generator.
//
// Ports:
//   i_clock     system clock, all state on posedge
//   i_reset     synchronous, active-high reset
//   i_tx_start  start pulse, only acted on while idle
//   i_tx_data   byte to send, captured when a start is accepted
//   i_tick      oversampling tick, one clock wide
//   o_tx        serial line (registered, idles high)
//   o_tx_busy   high while a frame is in progress
//   o_tx_done   one-cycle pulse in the first idle cycle after the stop period
module uart_tx #(
  parameter int unsigned NB_DATA       = 8,
  parameter int unsigned N_TICKS       = 16,
  parameter int unsigned SB_TICK       = 16,
  parameter int unsigned NB_TICK_COUNT = 5,
  parameter int unsigned NB_BIT_COUNT  = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_tick,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [NB_TICK_COUNT-1:0] BitTickLast  = NB_TICK_COUNT'(N_TICKS - 1);
  localparam logic [NB_TICK_COUNT-1:0] StopTickLast = NB_TICK_COUNT'(SB_TICK - 1);
  localparam logic [NB_BIT_COUNT-1:0]  BitLast      = NB_BIT_COUNT'(NB_DATA - 1);

  state_e                   state_q, state_d;
  logic [NB_TICK_COUNT-1:0] tick_q, tick_d;
  logic [NB_BIT_COUNT-1:0]  bit_q, bit_d;
  logic [NB_DATA-1:0]       shreg_q, shreg_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_tx_start) begin
          shreg_d = i_tx_data;
          tick_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (i_tick) begin
          if (tick_q == BitTickLast) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = StData;
          end else begin
            tick_d = tick_q + NB_TICK_COUNT'(1);
          end
        end
      end
      StData: begin
        if (i_tick) begin
          if (tick_q == BitTickLast) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == BitLast) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + NB_BIT_COUNT'(1);
            end
          end else begin
            tick_d = tick_q + NB_TICK_COUNT'(1);
          end
        end
      end
      StStop: begin
        if (i_tick) begin
          if (tick_q == StopTickLast) begin
            tick_d  = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + NB_TICK_COUNT'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the next state so o_tx changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = (state_q != StIdle);
  assign o_tx_done = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one byte per start pulse from the word transmitter stage and shifts it out LSB-first on a single line as a start bit, NB_DATA data bits and a stop period. Bit timing comes from an oversampling tick supplied by the baud-rate generator. A one-cycle done pulse tells the upstream word transmitter to present the next byte.

## Interface
- NB_DATA, 8: data bits per frame.
- N_TICKS, 16: i_tick pulses per start or data bit.
- SB_TICK, 16: i_tick pulses in the stop period; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- NB_TICK_COUNT, 5: tick counter width; must hold max(N_TICKS, SB_TICK) − 1.
- NB_BIT_COUNT, 3: data bit index width; must hold NB_DATA − 1.
- i_clock  in  1  system clock, all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_tx_start  in  1  start pulse; sampled only in IDLE.
- i_tx_data  in  NB_DATA  byte to send; sampled only on an accepted start.
- i_tick  in  1  baud oversampling tick, one clock wide.
- o_tx  out  1  serial line, registered.
- o_tx_busy  out  1  high while a frame is in progress.
- o_tx_done  out  1  one-cycle pulse at end of frame.

## Operation
- **FSM states:** IDLE, START, DATA, STOP. Internal registers:
  - state
  - tick counter (NB_TICK_COUNT)
  - bit index (NB_BIT_COUNT)
  - shift register (NB_DATA)
- **IDLE:** o_tx = 1.
  - i_tx_start = 1: latch i_tx_data into the shift register, clear the tick counter, go to START. The i_tick value is irrelevant.
- **START:** o_tx = 0.
  - i_tick = 1 and counter = N_TICKS−1: clear the counter, clear the bit index, go to DATA.
  - Other i_tick = 1: increment the counter.
- **DATA:** o_tx = shift register bit 0.
  - i_tick = 1 and counter = N_TICKS−1: clear the counter and shift the register right by 1.
    - Bit index = NB_DATA−1: go to STOP.
    - Otherwise: increment the bit index.
  - Other i_tick = 1: increment the counter.
- **STOP:** o_tx = 1.
  - i_tick = 1 and counter = SB_TICK−1: go to IDLE and assert o_tx_done.
  - Other i_tick = 1: increment the counter.
- **Busy and done:**
  - o_tx_busy = (state != IDLE).
  - o_tx_done is registered and high for exactly the first IDLE cycle after STOP.
- **Start while busy:** i_tx_start outside IDLE is ignored. The frame in flight and its data are unaffected, and no second frame is queued.
- **Data stability:** i_tx_data changes after acceptance have no effect.
- **Frame length:** (1 + NB_DATA)·N_TICKS + SB_TICK ticks. With defaults this is 160 ticks.
- **Reset:** state IDLE, o_tx = 1, o_tx_busy = 0, o_tx_done = 0, counters 0, shift register 0.
  - Reset mid-frame aborts the frame: the line returns high at the next edge and no done pulse is issued.

## Timing
- **Start latency:** i_tx_start high at edge k (state IDLE) → o_tx = 0 and o_tx_busy = 1 from edge k.
  - o_tx is registered alongside state, so there is zero extra cycle after acceptance.
- **Bit transitions:** each one occurs at the clock edge that samples the N_TICKS-th tick of the current bit.
- **End of frame:** the SB_TICK-th stop tick, sampled at edge m, gives state IDLE, o_tx_busy = 0 and o_tx_done = 1 during cycle m..m+1. o_tx_done returns to 0 at edge m+1.
- **Back-to-back frames:** i_tx_start high in the same cycle as o_tx_done is accepted at edge m+1.
  - o_tx goes low at edge m+1, giving one clock of idle-high between frames.
  - The upstream stage's own latency (done → next start) adds further idle cycles. Line protocol is unaffected.
- **Tick sparseness:** the tick may be arbitrarily sparse. Timing counts ticks, not clocks.
- **Continuous tick:** with i_tick tied high, one bit lasts exactly N_TICKS clocks.

## Test plan
1. **Reset:** assert i_reset for 3 cycles → o_tx = 1, o_tx_busy = 0, o_tx_done = 0; line stays high for 50 idle cycles.
2. **Single frame, continuous tick:** i_tick = 1 continuously, i_tx_start with i_tx_data = 0xA5.
   - Line, 16 clocks per bit: 0, then 1,0,1,0,0,1,0,1, then high for 16 clocks.
   - o_tx_done pulses once, exactly 160 clocks after acceptance.
3. **Sparse tick and stop length:** i_tick every 4th clock, data 0x00, SB_TICK = 32.
   - 9 low bits of 64 clocks each.
   - Stop high for 128 clocks.
   - o_tx_done 704 clocks after acceptance.
4. **Start while busy and data stability:** i_tx_start with 0x3C during the DATA state of a 0xA5 frame, i_tx_data changed to 0xFF.
   - Transmitted bits remain those of 0xA5.
   - Only one o_tx_done pulse; line high afterwards.
5. **Back-to-back frames:** i_tx_start asserted in the o_tx_done cycle with 0x81.
   - The next start bit begins one clock after the done pulse.
   - Second frame bits: 1,0,0,0,0,0,0,1.
6. **Reset mid-frame:** i_reset during DATA bit 3 of 0x55.
   - o_tx = 1 and o_tx_busy = 0 at the next edge; no o_tx_done.
   - A subsequent 0x0F frame is transmitted correctly.
